// File: rtl/mem_subsys_ws_if.sv
// Bus between the control FSM / datapath and mem_subsys_ws.
// master: control side that issues requests and supplies addresses/data.
// slave : the memory subsystem that returns registers and status.
interface mem_subsys_ws_if #(
    parameter int DATA_W = 16
);
    logic              req;
    logic              IorD;
    logic              wea;
    logic              IRWrite;
    logic [DATA_W-1:0] PCWire;
    logic [DATA_W-1:0] ALUoutWire;
    logic [DATA_W-1:0] bWire;
    logic [DATA_W-1:0] input_IO;
    logic [DATA_W-1:0] IRw;
    logic [DATA_W-1:0] Memoutw;
    logic [DATA_W-1:0] output_IO;
    logic              busy;
    logic              done;

    modport master (
        output req, IorD, wea, IRWrite, PCWire, ALUoutWire, bWire, input_IO,
        input  IRw, Memoutw, output_IO, busy, done
    );

    modport slave (
        input  req, IorD, wea, IRWrite, PCWire, ALUoutWire, bWire, input_IO,
        output IRw, Memoutw, output_IO, busy, done
    );
endinterface

// File: rtl/mem_subsys_ws.sv
// Memory subsystem with configurable wait states.
// One RAM access at a time: a request is latched in IDLE, waits WAIT_STATES
// cycles, commits on the edge entering DONE and pulses done for one cycle.
// Optional memory-mapped I/O decode is enabled by defining MEM_IO_MAP_EN.
module mem_subsys_ws #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 10,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] IO_IN_ADDR  = 10'h3FE,
    parameter logic [ADDR_W-1:0] IO_OUT_ADDR = 10'h3FF
) (
    input  logic           clk,
    input  logic           reset,
    mem_subsys_ws_if.slave bus
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_commit;
    logic              w_busy;
    logic              w_done;

    logic [ADDR_W-1:0] r_addr;
    logic              r_wea;
    logic              r_irwrite;
    logic [DATA_W-1:0] r_wdata;

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_memout;
    logic [DATA_W-1:0] r_ir;

    logic              w_in_idle;
    logic              w_accept;
    logic [DATA_W-1:0] w_sel;
    logic [ADDR_W-1:0] w_c_addr;
    logic              w_c_wea;
    logic              w_c_irwrite;
    logic [DATA_W-1:0] w_c_wdata;
    logic              w_io_in_hit;
    logic              w_io_out_hit;
    logic [DATA_W-1:0] w_rd_word;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_accept  = w_in_idle && bus.req;
    assign w_sel     = bus.IorD ? bus.ALUoutWire : bus.PCWire;

    // With zero wait states the commit edge is the accept edge, so the access
    // must use the live request fields; otherwise the latched copy is used.
    assign w_c_addr    = w_in_idle ? w_sel[ADDR_W-1:0] : r_addr;
    assign w_c_wea     = w_in_idle ? bus.wea           : r_wea;
    assign w_c_irwrite = w_in_idle ? bus.IRWrite       : r_irwrite;
    assign w_c_wdata   = w_in_idle ? bus.bWire         : r_wdata;

    // Next-state, commit strobe and status outputs
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_busy       = (r_state != S_IDLE);
        w_done       = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (WAIT_STATES > 0) begin
                        w_state_next = S_WAIT;
                    end else begin
                        w_state_next = S_DONE;
                        w_commit     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_DONE;
                    w_commit     = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register and wait-state counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt <= CNT_W'(WAIT_STATES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Capture the request so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr    <= w_sel[ADDR_W-1:0];
            r_wea     <= bus.wea;
            r_irwrite <= bus.IRWrite;
            r_wdata   <= bus.bWire;
        end
    end

`ifdef MEM_IO_MAP_EN
    logic [DATA_W-1:0] r_out_io;

    assign w_io_in_hit  = (w_c_addr == IO_IN_ADDR);
    assign w_io_out_hit = (w_c_addr == IO_OUT_ADDR);
    assign w_rd_word    = w_io_in_hit ? bus.input_IO : r_mem[w_c_addr];

    // Output port register loaded by writes to the output address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_io <= '0;
        end else if (w_commit && w_c_wea && w_io_out_hit) begin
            r_out_io <= w_c_wdata;
        end
    end

    assign bus.output_IO = r_out_io;
`else
    logic w_unused_io;

    assign w_io_in_hit   = 1'b0;
    assign w_io_out_hit  = 1'b0;
    assign w_rd_word     = r_mem[w_c_addr];
    assign w_unused_io   = ^{bus.input_IO, w_io_in_hit};
    assign bus.output_IO = '0;
`endif

    // RAM write port; a reset on the commit edge aborts the write
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_c_wea && !w_io_out_hit) begin
            r_mem[w_c_addr] <= w_c_wdata;
        end
    end

    // Registered read into Memoutw, and into IRw for instruction fetches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_memout <= '0;
            r_ir     <= '0;
        end else if (w_commit && !w_c_wea) begin
            r_memout <= w_rd_word;
            if (w_c_irwrite) begin
                r_ir <= w_rd_word;
            end
        end
    end

    assign bus.Memoutw = r_memout;
    assign bus.IRw     = r_ir;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;

endmodule

// File: tb/tb_mem_subsys_ws.sv
// Testbench for mem_subsys_ws: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a cycle-count model.
module tb_mem_subsys_ws;
    localparam int WS = 2;

`ifdef MEM_IO_MAP_EN
    localparam bit MAP = 1'b1;
`else
    localparam bit MAP = 1'b0;
`endif

    logic clk;
    logic reset;

    mem_subsys_ws_if #(.DATA_W(16)) bus ();
    mem_subsys_ws_if #(.DATA_W(16)) bus0 ();

    mem_subsys_ws #(.DATA_W(16), .ADDR_W(10), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    mem_subsys_ws #(.DATA_W(16), .ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the accept edge number; everything else follows from the
    // latency rules: commit at accept+WS, busy until accept+WS+1.
    longint      edge_n = 0;
    longint      m_acc  = 0;
    bit          m_inflight = 1'b0;
    bit          m_done = 1'b0;
    logic [9:0]  m_addr;
    bit          m_wea, m_irw;
    logic [15:0] m_wdata;
    logic [15:0] m_mem [1024];
    bit          m_known [1024];
    logic [15:0] m_memout = 16'h0, m_ir = 16'h0, m_out = 16'h0;
    bit          m_mo_known = 1'b0, m_ir_known = 1'b0;
    int          txn = 0;

    always @(posedge clk) begin
        logic [15:0] sel;
        logic [15:0] val;
        bit          known;
        edge_n++;
        if (reset) begin
            m_inflight = 1'b0;
            m_done     = 1'b0;
            m_memout   = 16'h0;
            m_ir       = 16'h0;
            m_out      = 16'h0;
            m_mo_known = 1'b1;
            m_ir_known = 1'b1;
        end else begin
            if (m_inflight && edge_n == m_acc + WS + 1) begin
                m_inflight = 1'b0;
            end else if (!m_inflight && bus.req) begin
                m_acc      = edge_n;
                m_inflight = 1'b1;
                sel        = bus.IorD ? bus.ALUoutWire : bus.PCWire;
                m_addr     = sel[9:0];
                m_wea      = bus.wea;
                m_irw      = bus.IRWrite;
                m_wdata    = bus.bWire;
            end
            m_done = m_inflight && (edge_n == m_acc + WS);
            if (m_done) begin
                txn++;
                if (m_wea) begin
                    if (MAP && m_addr == 10'h3FF) m_out = m_wdata;
                    else begin
                        m_mem[m_addr]   = m_wdata;
                        m_known[m_addr] = 1'b1;
                    end
                    $display("txn %0d: write addr=%h data=%h", txn, m_addr, m_wdata);
                end else begin
                    if (MAP && m_addr == 10'h3FE) begin
                        val = bus.input_IO; known = 1'b1;
                    end else begin
                        val = m_mem[m_addr]; known = m_known[m_addr];
                    end
                    m_memout = val; m_mo_known = known;
                    if (m_irw) begin
                        m_ir = val; m_ir_known = known;
                    end
                    $display("txn %0d: read  addr=%h data=%h ir=%0d", txn, m_addr, val, m_irw);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        chk("busy", {31'b0, bus.busy}, {31'b0, m_inflight});
        chk("done", {31'b0, bus.done}, {31'b0, m_done});
        if (m_mo_known) chk("Memoutw", {16'b0, bus.Memoutw}, {16'b0, m_memout});
        if (m_ir_known) chk("IRw", {16'b0, bus.IRw}, {16'b0, m_ir});
        chk("output_IO", {16'b0, bus.output_IO}, {16'b0, m_out});
    end

    // ---------------- stimulus helpers ----------------
    task automatic access(input bit w, input bit iord, input bit irw,
                          input logic [15:0] a, input logic [15:0] d, output int lat);
        @(negedge clk);
        bus.req = 1'b1; bus.wea = w; bus.IorD = iord; bus.IRWrite = irw; bus.bWire = d;
        if (iord) bus.ALUoutWire = a; else bus.PCWire = a;
        @(negedge clk);
        bus.req = 1'b0; bus.wea = ~w; bus.IorD = ~iord; bus.IRWrite = ~irw;
        bus.PCWire = 16'($urandom); bus.ALUoutWire = 16'($urandom); bus.bWire = 16'($urandom);
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [15:0] pick_addr();
        logic [9:0] lo;
        lo = ($urandom_range(0, 1) != 0) ? 10'(10'h3F8 + $urandom_range(0, 7))
                                         : 10'($urandom_range(0, 7));
        return {6'($urandom), lo};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        int nd;
        reset = 1'b1;
        bus.req = 0; bus.IorD = 0; bus.wea = 0; bus.IRWrite = 0;
        bus.PCWire = 0; bus.ALUoutWire = 0; bus.bWire = 0; bus.input_IO = 0;
        bus0.req = 0; bus0.IorD = 0; bus0.wea = 0; bus0.IRWrite = 0;
        bus0.PCWire = 0; bus0.ALUoutWire = 0; bus0.bWire = 0; bus0.input_IO = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_IRw", {16'b0, bus.IRw}, 32'd0);
        chk("rst_Memoutw", {16'b0, bus.Memoutw}, 32'd0);

        // Write then read
        access(1, 1, 0, 16'h0005, 16'hBEEF, lat);
        chk("wr_latency", lat, 32'd3);
        access(0, 1, 0, 16'h0005, 16'h0000, lat);
        chk("rd_latency", lat, 32'd3);
        chk("rd_Memoutw", {16'b0, bus.Memoutw}, 32'hBEEF);
        chk("rd_IRw_held", {16'b0, bus.IRw}, 32'h0);

        // Instruction fetch
        access(1, 1, 0, 16'h0010, 16'h1234, lat);
        access(0, 0, 1, 16'h0010, 16'h0000, lat);
        chk("fetch_IRw", {16'b0, bus.IRw}, 32'h1234);
        chk("fetch_Memoutw", {16'b0, bus.Memoutw}, 32'h1234);

        // Address wrap
        access(1, 1, 0, 16'h0401, 16'hAAAA, lat);
        access(0, 1, 0, 16'h0001, 16'h0000, lat);
        chk("wrap_Memoutw", {16'b0, bus.Memoutw}, 32'hAAAA);

        // Memory-mapped I/O (ordinary RAM when the decode is not built)
        access(1, 1, 0, 16'h03FE, 16'h1357, lat);
        access(1, 1, 0, 16'h03FF, 16'h00FF, lat);
        bus.input_IO = 16'h5A5A;
        access(0, 1, 0, 16'h03FE, 16'h0000, lat);
`ifdef MEM_IO_MAP_EN
        chk("io_in_Memoutw", {16'b0, bus.Memoutw}, 32'h5A5A);
        chk("io_out_reg", {16'b0, bus.output_IO}, 32'h00FF);
`else
        chk("ram_3FE_Memoutw", {16'b0, bus.Memoutw}, 32'h1357);
        chk("io_out_const0", {16'b0, bus.output_IO}, 32'h0);
        access(0, 1, 0, 16'h03FF, 16'h0000, lat);
        chk("ram_3FF_Memoutw", {16'b0, bus.Memoutw}, 32'h00FF);
`endif

        // Reset in WAIT aborts a write
        access(1, 1, 0, 16'h0020, 16'h0BAD, lat);
        @(negedge clk);
        bus.req = 1; bus.wea = 1; bus.IorD = 1; bus.ALUoutWire = 16'h0020; bus.bWire = 16'h1111;
        @(negedge clk);
        bus.req = 0;
        chk("busy_in_wait", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_IRw", {16'b0, bus.IRw}, 32'd0);
        chk("abort_Memoutw", {16'b0, bus.Memoutw}, 32'd0);
        chk("abort_output_IO", {16'b0, bus.output_IO}, 32'd0);
        access(0, 1, 0, 16'h0020, 16'h0000, lat);
        chk("abort_ram_kept", {16'b0, bus.Memoutw}, 32'h0BAD);

        // req while busy is ignored
        @(negedge clk);
        bus.req = 1; bus.wea = 0; bus.IorD = 1; bus.IRWrite = 0; bus.ALUoutWire = 16'h0005;
        @(negedge clk);
        bus.ALUoutWire = 16'h0010;
        @(negedge clk);
        bus.req = 0;
        lat = 0;
        while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
        chk("busy_req_Memoutw", {16'b0, bus.Memoutw}, 32'hBEEF);
        nd = 0;
        repeat (6) begin @(negedge clk); if (bus.done) nd++; end
        chk("busy_req_no_extra", nd, 32'd0);

        // Held req is re-accepted right after DONE
        @(negedge clk);
        bus.req = 1; bus.wea = 0; bus.IorD = 0; bus.IRWrite = 1; bus.PCWire = 16'h0010;
        nd = 0;
        repeat (8) begin @(negedge clk); if (bus.done) nd++; end
        bus.req = 0;
        chk("held_req_dones", nd, 32'd2);
        chk("held_req_IRw", {16'b0, bus.IRw}, 32'h1234);
        repeat (4) @(negedge clk);

        // Zero wait-state instance
        bus0.req = 1; bus0.wea = 1; bus0.IorD = 1; bus0.ALUoutWire = 16'h0030; bus0.bWire = 16'h4242;
        @(negedge clk);
        bus0.req = 0;
        chk("ws0_done", {31'b0, bus0.done}, 32'd1);
        chk("ws0_busy", {31'b0, bus0.busy}, 32'd1);
        @(negedge clk);
        chk("ws0_done_fall", {31'b0, bus0.done}, 32'd0);
        chk("ws0_busy_fall", {31'b0, bus0.busy}, 32'd0);
        bus0.req = 1; bus0.wea = 0; bus0.IRWrite = 1; bus0.ALUoutWire = 16'h0030;
        @(negedge clk);
        bus0.req = 0;
        chk("ws0_rd_done", {31'b0, bus0.done}, 32'd1);
        chk("ws0_rd_Memoutw", {16'b0, bus0.Memoutw}, 32'h4242);
        chk("ws0_rd_IRw", {16'b0, bus0.IRw}, 32'h4242);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            reset          = ($urandom_range(0, 299) == 0);
            bus.req        = ($urandom_range(0, 2) != 0);
            bus.wea        = 1'($urandom_range(0, 1));
            bus.IorD       = 1'($urandom_range(0, 1));
            bus.IRWrite    = 1'($urandom_range(0, 1));
            bus.PCWire     = pick_addr();
            bus.ALUoutWire = pick_addr();
            bus.bWire      = 16'($urandom);
            bus.input_IO   = 16'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.req = 1'b0;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
